// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port
// and the load/store port. It grants one request at a time, tracks a
// variable-latency memory transaction, and aborts it on timeout.
//
// Handshake: a requester raises *_req with its address and data stable and
// holds them until it sees *_ack. *_ack is a one-cycle pulse that carries
// *_rdata. In the cycle that *_ack is high, the same requester is not
// eligible for a new grant, so a request still held during its ack cycle
// does not start a second transaction. On the memory side, mem_req is held
// with stable mem_addr/mem_wen/mem_wdata until mem_ready is sampled high.
// mem_ready is ignored outside the busy states.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_wen,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                cpu_stall,
  output logic                err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  // A zero timeout still needs a one-bit counter so the port widths stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  logic grant_dm;
  logic grant_if;
  logic complete;
  logic abort;
  logic timeout_hit;

  assign state_dbg = state_q;

  // Stall the CPU while either port has an outstanding, un-acked request.
  assign cpu_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load/store wins in IDLE; a busy state ends on ready or timeout.
  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && !dm_ack) begin
          grant_dm = 1'b1;
          state_d  = DM_BUSY;
        end else if (if_req && !if_ack) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs, return data, ack pulses, busy counter and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      err       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_addr  <= dm_addr;
        mem_wen   <= dm_wen;
        mem_wdata <= dm_wdata;
        cnt_q     <= '0;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_addr  <= if_addr;
        mem_wen   <= '0;
        mem_wdata <= '0;
        cnt_q     <= '0;
      end else if (complete) begin
        mem_req <= 1'b0;
        mem_wen <= '0;
        if (state_q == DM_BUSY) begin
          dm_rdata <= mem_rdata;
          dm_ack   <= 1'b1;
        end else begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end
      end else if (abort) begin
        // A hung transaction returns a recognisable poison word and latches err.
        mem_req <= 1'b0;
        mem_wen <= '0;
        err     <= 1'b1;
        if (state_q == DM_BUSY) begin
          dm_rdata <= ABORT_DATA;
          dm_ack   <= 1'b1;
        end else begin
          if_rdata <= ABORT_DATA;
          if_ack   <= 1'b1;
        end
      end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
